// File: rtl/iq_entry_allocator.sv
// -----------------------------------------------------------------------------
// iq_entry_allocator
//
// Free list of issue queue entry indices. It is a circular FIFO of index slots.
// Dispatch lanes pop indices from the head, and issue/squash lanes push
// indices back at the tail. A pipeline flush rebuilds the identity list.
//
// Ports
//   clk            clock
//   rst            synchronous active-high reset; overrides every other input
//   allocReq[i]    dispatch lane i wants an entry this cycle
//   allocPtr[i]    entry index granted to lane i (combinational from state)
//   allocatable    at least ALLOC_WIDTH entries are free
//   releaseValid[j] lane j returns the entry index releasePtr[j]
//   releasePtr[j]  index being returned by lane j
//   flushAll       return every entry; rebuilds the post-reset list
//   freeCount      registered number of free entries
//   overflowErr    sticky; a release would have pushed the count past full
// -----------------------------------------------------------------------------
module iq_entry_allocator #(
   parameter int ENTRY_NUM     = 16,
   parameter int ALLOC_WIDTH   = 2,
   parameter int RELEASE_WIDTH = 2,
   localparam int PTR_W        = $clog2(ENTRY_NUM),
   localparam int CNT_W        = PTR_W + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ALLOC_WIDTH-1:0]   allocReq,
   output logic [PTR_W-1:0]         allocPtr [ALLOC_WIDTH],
   output logic                     allocatable,
   input  logic [RELEASE_WIDTH-1:0] releaseValid,
   input  logic [PTR_W-1:0]         releasePtr [RELEASE_WIDTH],
   input  logic                     flushAll,
   output logic [CNT_W-1:0]         freeCount,
   output logic                     overflowErr
);

   // Widths able to hold a lane popcount of 0..WIDTH.
   localparam int AW_W  = $clog2(ALLOC_WIDTH + 1);
   localparam int RW_W  = $clog2(RELEASE_WIDTH + 1);
   // The pre-saturation count can exceed ENTRY_NUM by up to RELEASE_WIDTH.
   localparam int SUM_W = CNT_W + RW_W;

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [PTR_W-1:0] slot [ENTRY_NUM];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             overflow_err_q;

   // --------------------------------------------------------------------------
   // Allocation side
   // --------------------------------------------------------------------------
   logic [AW_W-1:0] alloc_cnt;
   logic [AW_W-1:0] n_alloc_eff;

   assign allocatable = (count >= CNT_W'(ALLOC_WIDTH));

   // Each requesting lane takes the next slot after those claimed by the lower
   // lanes. So grants stay packed in FIFO order even when the requesting lanes
   // are not contiguous.
   // NOTE: blocking assignments are used here on purpose. The running
   // popcount has to be updated lane by lane inside one combinational
   // evaluation, and every output is given a value on every path, so no latch
   // is inferred.
   always_comb begin
      alloc_cnt = '0;
      for (int i = 0; i < ALLOC_WIDTH; i++) begin
         allocPtr[i] = slot[head + PTR_W'(alloc_cnt)];
         alloc_cnt   = alloc_cnt + AW_W'(allocReq[i]);
      end
   end

   // Requests are ignored while fewer than ALLOC_WIDTH entries are free.
   // Dispatch stalls as a whole, so no partial group is granted.
   assign n_alloc_eff = allocatable ? alloc_cnt : '0;

   // --------------------------------------------------------------------------
   // Release side
   // --------------------------------------------------------------------------
   logic [RW_W-1:0]  rel_cnt;
   logic [PTR_W-1:0] rel_addr [RELEASE_WIDTH];

   // Valid releases are packed at the tail in lane order. Invalid lanes
   // consume no slot.
   always_comb begin
      rel_cnt = '0;
      for (int j = 0; j < RELEASE_WIDTH; j++) begin
         rel_addr[j] = tail + PTR_W'(rel_cnt);
         rel_cnt     = rel_cnt + RW_W'(releaseValid[j]);
      end
   end

   // --------------------------------------------------------------------------
   // Count update
   // --------------------------------------------------------------------------
   logic [SUM_W-1:0] count_sum;
   logic             overflow;
   logic [CNT_W-1:0] count_next;

   // Subtraction cannot underflow. An allocation only takes effect when count
   // already covers ALLOC_WIDTH, and n_alloc_eff never exceeds that.
   assign count_sum  = SUM_W'(count) + SUM_W'(rel_cnt) - SUM_W'(n_alloc_eff);
   assign overflow   = (count_sum > SUM_W'(ENTRY_NUM));
   assign count_next = overflow ? CNT_W'(ENTRY_NUM) : CNT_W'(count_sum);

   // --------------------------------------------------------------------------
   // Sequential state
   // --------------------------------------------------------------------------
   // NOTE: all state below uses non-blocking assignments. Every register
   // then samples the pre-edge values, which is what lets head and tail move
   // independently in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || flushAll) begin
         head  <= '0;
         tail  <= '0;
         count <= CNT_W'(ENTRY_NUM);
         // NOTE: the slot array is deliberately reset. The free list must
         // start out as the identity permutation, so these slots are
         // architectural state and not scratch storage.
         for (int k = 0; k < ENTRY_NUM; k++) begin
            slot[k] <= PTR_W'(k);
         end
      end else begin
         head  <= head + PTR_W'(n_alloc_eff);
         tail  <= tail + PTR_W'(rel_cnt);
         count <= count_next;
         // A release that overflows the list is still written. The error
         // flag records that the contents can no longer be trusted.
         for (int j = 0; j < RELEASE_WIDTH; j++) begin
            if (releaseValid[j]) begin
               slot[rel_addr[j]] <= releasePtr[j];
            end
         end
      end
   end

   // A flush blocks that cycle's releases, so it cannot raise the error.
   // A flush also does not clear an error that is already recorded.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_err_q <= 1'b0;
      end else if (overflow && !flushAll) begin
         overflow_err_q <= 1'b1;
      end
   end

   assign freeCount   = count;
   assign overflowErr = overflow_err_q;

endmodule

// File: tb/tb_iq_entry_allocator.sv
// -----------------------------------------------------------------------------
// tb_iq_entry_allocator
//
// Directed bench for iq_entry_allocator (16 entries, 2 alloc lanes,
// 2 release lanes). Inputs change 1 time unit after the rising edge, and
// outputs are sampled one more unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_iq_entry_allocator;

   localparam int ENTRY_NUM     = 16;
   localparam int ALLOC_WIDTH   = 2;
   localparam int RELEASE_WIDTH = 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [ALLOC_WIDTH-1:0]   allocReq;
   logic [3:0]               allocPtr [ALLOC_WIDTH];
   logic                     allocatable;
   logic [RELEASE_WIDTH-1:0] releaseValid;
   logic [3:0]               releasePtr [RELEASE_WIDTH];
   logic                     flushAll;
   logic [4:0]               freeCount;
   logic                     overflowErr;

   int tests_run = 0;
   int tests_failed = 0;

   iq_entry_allocator #(
      .ENTRY_NUM    (ENTRY_NUM),
      .ALLOC_WIDTH  (ALLOC_WIDTH),
      .RELEASE_WIDTH(RELEASE_WIDTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .allocReq    (allocReq),
      .allocPtr    (allocPtr),
      .allocatable (allocatable),
      .releaseValid(releaseValid),
      .releasePtr  (releasePtr),
      .flushAll    (flushAll),
      .freeCount   (freeCount),
      .overflowErr (overflowErr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      allocReq      = '0;
      releaseValid  = '0;
      releasePtr[0] = '0;
      releasePtr[1] = '0;
      flushAll      = 1'b0;
   endtask

   task automatic release2(input logic [1:0] v, input logic [3:0] p0, input logic [3:0] p1);
      releaseValid  = v;
      releasePtr[0] = p0;
      releasePtr[1] = p1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_grants(input string tag, input int g0, input int g1);
      check({tag, ".ptr0"}, 32'(allocPtr[0]), g0);
      check({tag, ".ptr1"}, 32'(allocPtr[1]), g1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
      settle();

      // Reset state
      check("rst.freeCount",   32'(freeCount),   16);
      check("rst.allocatable", 32'(allocatable), 1);
      check("rst.overflowErr", 32'(overflowErr), 0);

      // Both lanes from reset; zero-cycle grant, then the next pair
      allocReq = 2'b11;
      settle();
      check_grants("both.first", 0, 1);
      tick();
      check_grants("both.second", 2, 3);
      check("both.freeCount", 32'(freeCount), 14);

      // Lane 1 only; it takes the head slot, head moves by one
      do_reset();
      allocReq = 2'b10;
      settle();
      check("lane1.ptr1", 32'(allocPtr[1]), 0);
      tick();
      allocReq = 2'b11;
      settle();
      check("lane1.freeCount", 32'(freeCount), 15);
      check_grants("lane1.head1", 1, 2);

      // Drain all 16 entries
      do_reset();
      allocReq = 2'b11;
      for (int c = 0; c < 8; c++) begin
         settle();
         check_grants($sformatf("drain.c%0d", c), 2 * c, 2 * c + 1);
         tick();
      end
      check("drain.freeCount",   32'(freeCount),   0);
      check("drain.allocatable", 32'(allocatable), 0);
      tick();
      check("empty.noalloc.freeCount", 32'(freeCount), 0);

      // One release into an empty list is not enough to dispatch
      idle();
      release2(2'b01, 4'd5, 4'd0);
      tick();
      idle();
      check("rel5.freeCount",   32'(freeCount),   1);
      check("rel5.allocatable", 32'(allocatable), 0);

      // Refill slots 1..14 with values 1..14 (tail moves to 15)
      for (int c = 0; c < 7; c++) begin
         release2(2'b11, 4'(2 * c + 1), 4'(2 * c + 2));
         tick();
      end
      idle();
      check("refill.freeCount", 32'(freeCount), 15);

      // Allocate 13 entries: six pairs, then lane 1 alone
      allocReq = 2'b11;
      for (int c = 0; c < 6; c++) begin
         settle();
         if (c == 0) check_grants("realloc.c0", 5, 1);
         else        check_grants($sformatf("realloc.c%0d", c), 2 * c, 2 * c + 1);
         tick();
      end
      allocReq = 2'b10;
      settle();
      check("realloc.lane1", 32'(allocPtr[1]), 12);
      tick();
      idle();
      check("realloc.freeCount", 32'(freeCount), 2);

      // Allocation and release together at the wrap point
      allocReq = 2'b11;
      release2(2'b11, 4'd7, 4'd9);
      settle();
      check_grants("simul.old", 13, 14);
      tick();
      idle();
      allocReq = 2'b11;
      settle();
      check("simul.freeCount", 32'(freeCount), 2);
      check_grants("simul.wrap", 7, 9);

      // A flush beats same-cycle allocation and release
      allocReq = 2'b11;
      release2(2'b11, 4'd4, 4'd6);
      flushAll = 1'b1;
      tick();
      idle();
      allocReq = 2'b11;
      settle();
      check("flush.freeCount",   32'(freeCount),   16);
      check("flush.overflowErr", 32'(overflowErr), 0);
      check_grants("flush.first", 0, 1);
      tick();
      check_grants("flush.second", 2, 3);
      check("flush.freeCount2", 32'(freeCount), 14);

      // A release into a full list sets the sticky error; the slot is still written
      do_reset();
      release2(2'b01, 4'd3, 4'd0);
      tick();
      idle();
      check("ovf.overflowErr", 32'(overflowErr), 1);
      check("ovf.freeCount",   32'(freeCount),   16);
      allocReq = 2'b11;
      settle();
      check_grants("ovf.written", 3, 1);
      tick();
      idle();
      check("ovf.freeCount2",  32'(freeCount),   14);
      check("ovf.sticky",      32'(overflowErr), 1);
      flushAll = 1'b1;
      tick();
      idle();
      check("ovf.flushKeeps",  32'(overflowErr), 1);
      check("ovf.flushCount",  32'(freeCount),   16);

      // Reset discards in-flight activity and clears the error
      rst      = 1'b1;
      allocReq = 2'b11;
      release2(2'b11, 4'd8, 4'd10);
      tick();
      rst = 1'b0;
      idle();
      allocReq = 2'b11;
      settle();
      check("rstmid.overflowErr", 32'(overflowErr), 0);
      check("rstmid.freeCount",   32'(freeCount),   16);
      check("rstmid.allocatable", 32'(allocatable), 1);
      check_grants("rstmid.grants", 0, 1);
      idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/iq_entry_allocator.md
IQ_ENTRY_ALLOCATOR -- requirements
Module: iq_entry_allocator

Interface
REQ-001 The block SHALL take parameter ENTRY_NUM, default 16, number of issue queue entries; power of two, at least 4.
REQ-002 The block SHALL take parameter ALLOC_WIDTH, default 2, dispatch lanes that may claim an entry per cycle.
REQ-003 The block SHALL take parameter RELEASE_WIDTH, default 2, issue/squash lanes that may return an entry per cycle.
REQ-004 The block SHALL use a single clock and a synchronous, active-high reset, with ports in this order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- allocReq[ALLOC_WIDTH]  in  1 each  lane i requests an entry.
- allocPtr[ALLOC_WIDTH]  out  log2(ENTRY_NUM) each  entry index granted to lane i.
- allocatable  out  1  ALLOC_WIDTH entries are free; dispatch may proceed this cycle.
- releaseValid[RELEASE_WIDTH]  in  1 each  lane j returns an entry.
- releasePtr[RELEASE_WIDTH]  in  log2(ENTRY_NUM) each  index being returned.
- flushAll  in  1  pipeline-wide recovery; all entries become free.
- freeCount  out  log2(ENTRY_NUM)+1  current number of free entries.
- overflowErr  out  1  sticky; a release was attempted while the list was full.

Function
REQ-005 The free list SHALL be a circular FIFO of ENTRY_NUM index slots with a head pointer, a tail pointer and a count; pointers wrap modulo ENTRY_NUM.
REQ-006 allocatable SHALL be asserted combinationally when count >= ALLOC_WIDTH, independent of allocReq.
REQ-007 allocPtr[i] SHALL equal slot[(head + k) mod ENTRY_NUM], where k is the number of asserted allocReq in lanes below i.
- Combinational from current state; zero-cycle grant.
- Lanes may be non-contiguous; granted indices stay packed in FIFO order.
REQ-008 On a clock edge with allocatable high, head SHALL advance by nAlloc, the popcount of allocReq.
REQ-009 With allocatable low, allocReq SHALL be ignored: head is unchanged and allocPtr is don't-care.
REQ-010 Each asserted releaseValid[j] SHALL write releasePtr[j] to slot[(tail + m) mod ENTRY_NUM], where m is the number of valid releases in lanes below j; tail then advances by nRel.
REQ-011 Next count SHALL be count - nAlloc(effective) + nRel.
- Arithmetic at log2(ENTRY_NUM)+1 bits; never negative.
- Never exceeds ENTRY_NUM in legal operation.
REQ-012 An entry released in cycle t SHALL NOT be grantable before cycle t+1; there is no release-to-alloc bypass.
REQ-013 Simultaneous allocation and release in one cycle SHALL both take effect; head and tail update independently.
REQ-014 If count + nRel - nAlloc(effective) > ENTRY_NUM, overflowErr SHALL set and hold until reset.
- The offending releases are still written.
- tail advances; count saturates at ENTRY_NUM.
REQ-015 flushAll SHALL take priority over allocation and release in the same cycle.
- Next state is identical to the post-reset state: head=0, tail=0, count=ENTRY_NUM, slot[k]=k.
- overflowErr is unaffected.
REQ-016 freeCount SHALL equal the registered count.
REQ-017 The block SHALL NOT detect duplicate releases; the issue queue guarantees uniqueness.

Reset
REQ-018 rst SHALL have priority over flushAll and all other inputs.
REQ-019 After reset: slot[k]=k for all k, head=0, tail=0, count=ENTRY_NUM, freeCount=ENTRY_NUM, overflowErr=0, allocatable=1.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight allocations and releases of that cycle.

Verification (ENTRY_NUM=16, ALLOC_WIDTH=2, RELEASE_WIDTH=2)
REQ-021 Reset, then allocReq=11 -> allocPtr={0,1}; next cycle allocPtr={2,3}, freeCount=14.
REQ-022 allocReq=10 (lane1 only) from reset -> allocPtr[1]=0; next cycle freeCount=15 and head=1.
REQ-023 Drain the list with 8 cycles of allocReq=11:
- After the drain: freeCount=0, allocatable=0.
- allocReq=11 in the next cycle -> no state change.
- Release {5} -> the following cycle freeCount=1, allocatable still 0.
REQ-024 With freeCount=2, apply allocReq=11 and release {7,9} in the same cycle:
- Grants are the two old head entries.
- Next freeCount=2; the next grants are {7,9}, confirming tail wrap.
REQ-025 Mid-stream flushAll together with allocReq=11 and releases:
- Next cycle freeCount=16.
- allocPtr={0,1}; no released index appears early.
REQ-026 From reset (full), releaseValid=01 -> overflowErr=1 next cycle, freeCount=16; overflowErr clears only on rst.
